// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types, constants and result-narrowing helper for matmul_sequencer
package matmul_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int SAT_W        = 64;

  // Narrows an accumulator to dw bits, either truncating or clamping to all-ones.
  function automatic logic [SAT_W-1:0] sat_trunc(input logic [SAT_W-1:0] acc,
                                                 input int dw,
                                                 input bit sat);
    logic [SAT_W-1:0] mask;
    mask = (SAT_W'(1) << dw) - SAT_W'(1);
    if (sat && ((acc & ~mask) != '0)) sat_trunc = mask;
    else                              sat_trunc = acc & mask;
  endfunction

endpackage

// File: rtl/matmul_index_ctr.sv
// rtl/matmul_index_ctr.sv - i/j/k loop counters and A/B/R address generation
module matmul_index_ctr
  import matmul_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int AW   = $clog2(SIZE*SIZE),
  parameter int CW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc_k,
  input  logic          inc_j,
  output logic          first_k,
  output logic          last_k,
  output logic          last_ij,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic [AW-1:0] r_addr
);

  logic [CW-1:0] i, j, k;
  logic          last_i, last_j;

  assign last_i  = (i == CW'(SIZE-1));
  assign last_j  = (j == CW'(SIZE-1));
  assign last_k  = (k == CW'(SIZE-1));
  assign first_k = (k == '0);
  assign last_ij = last_i && last_j;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (inc_k) k <= last_k ? '0 : k + CW'(1);
      // j wraps into i; after the final element both return to zero
      if (inc_j) begin
        if (last_j) begin
          j <= '0;
          i <= last_i ? '0 : i + CW'(1);
        end else begin
          j <= j + CW'(1);
        end
      end
    end
  end

  assign a_addr = AW'(i) * AW'(SIZE) + AW'(k);
  assign b_addr = AW'(k) * AW'(SIZE) + AW'(j);
  assign r_addr = AW'(i) * AW'(SIZE) + AW'(j);

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - SIZE x SIZE matrix multiply sequencer; MATMUL_SATURATE_EN selects saturating R output
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int DW   = 16,
  parameter int ACCW = 32,
  localparam int AW  = $clog2(SIZE*SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] a_data,
  input  logic [DW-1:0] b_data,
  output logic          r_we,
  output logic [AW-1:0] r_addr,
  output logic [DW-1:0] r_data
);

  localparam int CW = $clog2(SIZE);
  localparam int PW = 2*DW;
`ifdef MATMUL_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t state_q, state_d;
  logic [1:0] drain_cnt;
  logic clr, inc_k, inc_j, first_k, last_k, last_ij;

  logic          v1, f1, v2, f2;
  logic [PW-1:0] product;
  logic [ACCW-1:0] acc;

  matmul_index_ctr #(.SIZE(SIZE), .AW(AW), .CW(CW)) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .inc_k   (inc_k),
    .inc_j   (inc_j),
    .first_k (first_k),
    .last_k  (last_k),
    .last_ij (last_ij),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .r_addr  (r_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || state_q != DRAIN) drain_cnt <= '0;
    else                           drain_cnt <= drain_cnt + 2'd1;
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    inc_k   = 1'b0;
    inc_j   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        inc_k = 1'b1;
        if (last_k) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == 2'(DRAIN_CYCLES-1)) state_d = WRITE;
      end
      WRITE: begin
        inc_j   = 1'b1;
        state_d = last_ij ? DONE : ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // valid/first tags ride alongside the read and multiply stages
  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      f1      <= 1'b0;
      v2      <= 1'b0;
      f2      <= 1'b0;
      product <= '0;
      acc     <= '0;
    end else begin
      v1 <= (state_q == ISSUE);
      f1 <= (state_q == ISSUE) && first_k;
      v2 <= v1;
      f2 <= f1;
      if (v1) product <= PW'(a_data) * PW'(b_data);
      if (v2) acc <= f2 ? ACCW'(product) : acc + ACCW'(product);
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign r_we   = (state_q == WRITE);
  assign r_data = DW'(sat_trunc(SAT_W'(acc), DW, SAT_EN));

endmodule
